iob_iob2wishbone: RTL and testbench

Bridge from an IOb slave port to a Wishbone classic-cycle master port, for CPU-side IOb masters accessing Wishbone peripherals such as the Ethernet MAC register file. It latches one IOb request and runs one Wishbone cycle (CYC/STB held until ACK, ERR or timeout). It then returns a single-cycle IOb ready pulse with the registered read data. One outstanding transaction at a time.

---
 rtl/iob_iob2wishbone_pkg.sv | 10 +
 rtl/iob_reg.sv | 26 ++
 rtl/iob_timeout_cnt.sv | 41 ++++
 rtl/iob_iob2wishbone.sv | 140 ++++++++++++++
 tb/tb_iob_iob2wishbone.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/iob_iob2wishbone_pkg.sv
// rtl/iob_iob2wishbone_pkg.sv - shared FSM encoding for the IOb to Wishbone bridge
package iob_iob2wishbone_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/iob_reg.sv
// rtl/iob_reg.sv - enabled register with asynchronous active-high reset
// Ports: clk_i, arst_i, en_i (load enable), data_i (next value), data_o (registered value)
module iob_reg #(
  parameter int                 DATA_W  = 32,
  parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      data_q <= RST_VAL;
    end else if (en_i) begin
      data_q <= data_i;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/iob_timeout_cnt.sv
// rtl/iob_timeout_cnt.sv - saturating bus-timeout counter with terminal-count flag
// Ports: clk_i, arst_i, clear_i (restart from 0), en_i (count one cycle),
//        done_o (count has reached LIMIT-1; never set when LIMIT is 0)
module iob_timeout_cnt #(
  parameter int CNT_W = 8,
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic done_o
);

  localparam bit               ENABLED = (LIMIT != 0);
  localparam int               LAST_I  = ENABLED ? LIMIT - 1 : 0;
  localparam logic [CNT_W-1:0] LAST    = LAST_I[CNT_W-1:0];

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturate at all-ones so a disabled timeout can never wrap back into range.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = ENABLED && (cnt_q == LAST);

endmodule

// File: rtl/iob_iob2wishbone.sv
// rtl/iob_iob2wishbone.sv - IOb slave to Wishbone classic master bridge, one outstanding access
// Ports: IOb side  valid_i/address_i/wdata_i/wstrb_i in, rdata_o/ready_o/error_o/overrun_o out
//        WB side   wb_addr_o/wb_select_o/wb_we_o/wb_cyc_o/wb_stb_o/wb_data_o out,
//                  wb_data_i/wb_ack_i/wb_error_i in
module iob_iob2wishbone #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_W      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                valid_i,
  input  logic [ADDR_W-1:0]   address_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                ready_o,
  output logic                error_o,
  output logic                overrun_o,
  output logic [ADDR_W-1:0]   wb_addr_o,
  output logic [DATA_W/8-1:0] wb_select_o,
  output logic                wb_we_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic [DATA_W-1:0]   wb_data_o,
  input  logic [DATA_W-1:0]   wb_data_i,
  input  logic                wb_ack_i,
  input  logic                wb_error_i
);

  import iob_iob2wishbone_pkg::*;

  localparam int STRB_W = DATA_W / 8;
  localparam int REQ_W  = ADDR_W + DATA_W + STRB_W + 1;

  state_t              state_q, state_d;
  logic                cyc_q, cyc_d;
  logic                ready_q, ready_d;
  logic                error_q, error_d;
  logic                overrun_q, overrun_d;
  logic                req_en, end_en, cnt_en;
  logic                term, tmo_done;
  logic                we_in;
  logic [STRB_W-1:0]   sel_in;
  logic [DATA_W-1:0]   rdata_d;

  assign term   = wb_ack_i | wb_error_i;
  assign we_in  = |wstrb_i;
  assign sel_in = we_in ? wstrb_i : {STRB_W{1'b1}};

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (valid_i) state_d = ST_BUS;
      ST_BUS:  if (term || tmo_done) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_en    = (state_q == ST_IDLE) && valid_i;
    end_en    = (state_q == ST_BUS) && (term || tmo_done);
    cnt_en    = (state_q == ST_BUS) && !term;
    ready_d   = (state_q == ST_RESP);
    overrun_d = valid_i && (state_q != ST_IDLE);

    cyc_d = cyc_q;
    if (req_en) begin
      cyc_d = 1'b1;
    end else if (end_en) begin
      cyc_d = 1'b0;
    end

    // Only a clean ACK on a read returns slave data; ERR, timeout and writes return zero.
    rdata_d = (term && !wb_error_i && !wb_we_o) ? wb_data_i : '0;

    // error_o must stay valid alongside ready_o, so it is cleared only after the ready pulse.
    error_d = error_q;
    if (end_en) begin
      error_d = wb_error_i | ~term;
    end else if (ready_q) begin
      error_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cyc_q     <= 1'b0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      cyc_q     <= cyc_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
      overrun_q <= overrun_d;
    end
  end

  iob_reg #(.DATA_W(REQ_W)) u_req_reg (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .en_i   (req_en),
    .data_i ({address_i, wdata_i, sel_in, we_in}),
    .data_o ({wb_addr_o, wb_data_o, wb_select_o, wb_we_o})
  );

  iob_reg #(.DATA_W(DATA_W)) u_rdata_reg (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .en_i   (end_en),
    .data_i (rdata_d),
    .data_o (rdata_o)
  );

  iob_timeout_cnt #(.CNT_W(TIMEOUT_W), .LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk_i   (clk_i),
    .arst_i  (arst_i),
    .clear_i (req_en),
    .en_i    (cnt_en),
    .done_o  (tmo_done)
  );

  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign ready_o   = ready_q;
  assign error_o   = error_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_iob_iob2wishbone.sv
// tb/tb_iob_iob2wishbone.sv - self-checking bench for the IOb to Wishbone bridge
module tb_iob_iob2wishbone;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 16;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          arst = 1'b1;
  logic          valid = 1'b0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] wdata = '0;
  logic [SW-1:0] wstrb = '0;
  logic [DW-1:0] rdata;
  logic          ready, error, overrun;
  logic [AW-1:0] wb_addr;
  logic [SW-1:0] wb_sel;
  logic          wb_we, wb_cyc, wb_stb;
  logic [DW-1:0] wb_dout;
  logic [DW-1:0] wb_din = 32'hBAD0_BAD0;
  logic          wb_ack = 1'b0;
  logic          wb_err = 1'b0;

  int   total = 0;
  int   bad = 0;
  int   cycle = 0;
  int   t_valid = 0;
  exp_t sb[$];
  logic [70:0] exp_hold;

  iob_iob2wishbone #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_W(8), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk), .arst_i(arst), .valid_i(valid), .address_i(address),
    .wdata_i(wdata), .wstrb_i(wstrb), .rdata_o(rdata), .ready_o(ready),
    .error_o(error), .overrun_o(overrun), .wb_addr_o(wb_addr),
    .wb_select_o(wb_sel), .wb_we_o(wb_we), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb),
    .wb_data_o(wb_dout), .wb_data_i(wb_din), .wb_ack_i(wb_ack), .wb_error_i(wb_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                       input bit push, input logic [DW-1:0] er, input logic ee);
    logic [SW-1:0] sel;
    sel      = (|s) ? s : {SW{1'b1}};
    exp_hold = {1'b1, 1'b1, a, d, sel, |s};
    address  = a;
    wdata    = d;
    wstrb    = s;
    valid    = 1'b1;
    t_valid  = cycle;
    if (push) sb.push_back('{rdata: er, err: ee});
    step();
    valid = 1'b0;
    check("cyc_rise", wb_cyc, 1);
    check("stb_rise", wb_stb, 1);
    check("wb_addr", wb_addr, a);
    check("wb_we", wb_we, |s);
    check("wb_select", wb_sel, sel);
    check("wb_wdata", wb_dout, d);
  endtask

  task automatic slave_end(input int waits, input bit a, input bit e, input logic [DW-1:0] d);
    for (int i = 0; i < waits; i++) begin
      step();
      check("wb_hold", {wb_cyc, wb_stb, wb_addr, wb_dout, wb_sel, wb_we}, exp_hold);
    end
    wb_ack = a;
    wb_err = e;
    wb_din = d;
    step();
    wb_ack = 1'b0;
    wb_err = 1'b0;
    wb_din = 32'hBAD0_BAD0;
    check("cyc_drop", {wb_cyc, wb_stb}, 0);
    check("ready_early", ready, 0);
  endtask

  task automatic wait_ready(input int budget, input int exp_lat);
    exp_t e;
    int   n;
    n = 0;
    while (!ready && n < budget) begin
      step();
      n++;
    end
    check("ready_seen", ready, 1);
    if (ready) begin
      check("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("rdata", rdata, e.rdata);
        check("error", error, e.err);
      end
      check("latency", cycle - t_valid, exp_lat);
      step();
      check("ready_pulse_len", ready, 0);
      check("error_clear", error, 0);
    end
  endtask

  initial begin
    int n;

    // reset state
    step();
    step();
    check("rst_cyc_stb", {wb_cyc, wb_stb}, 0);
    check("rst_ready_err_ovr", {ready, error, overrun}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_req_regs", {wb_addr, wb_dout, wb_sel, wb_we}, 0);
    arst = 1'b0;
    step();

    // read, ack in first BUS cycle
    issue(32'h0000_0040, 32'h0, 4'b0000, 1, 32'hDEAD_BEEF, 0);
    slave_end(0, 1, 0, 32'hDEAD_BEEF);
    wait_ready(10, 3);
    check("addr_retained", wb_addr, 32'h0000_0040);

    // write, 4 wait cycles, junk on wb_data_i at ack must not leak into rdata
    issue(32'h0000_0010, 32'h1234_5678, 4'b0011, 1, 32'h0, 0);
    slave_end(4, 1, 0, 32'h5555_AAAA);
    wait_ready(10, 7);

    // ACK and ERR together on a read
    issue(32'h0000_0020, 32'h0, 4'b0000, 1, 32'h0, 1);
    slave_end(1, 1, 1, 32'h7777_7777);
    wait_ready(10, 4);

    // timeout: no termination, CYC/STB high for exactly TMO cycles
    issue(32'h0000_0030, 32'h0, 4'b0000, 1, 32'h0, 1);
    n = 0;
    while (wb_cyc && n < 40) begin
      step();
      n++;
    end
    check("timeout_cyc_len", n, TMO);
    wait_ready(10, TMO + 2);
    wb_ack = 1'b1;
    wb_din = 32'h1111_1111;
    step();
    wb_ack = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (wb_cyc || ready || error) n++;
      step();
    end
    check("late_ack_ignored", n, 0);

    // overrun: second valid one cycle after the first
    issue(32'h0000_0044, 32'h0, 4'b0000, 1, 32'hA5A5_0001, 0);
    address = 32'h0000_0999;
    wdata   = 32'hFFFF_FFFF;
    wstrb   = 4'hF;
    valid   = 1'b1;
    step();
    valid = 1'b0;
    check("overrun_pulse", overrun, 1);
    check("overrun_addr_kept", {wb_addr, wb_we}, {32'h0000_0044, 1'b0});
    step();
    check("overrun_single", overrun, 0);
    slave_end(0, 1, 0, 32'hA5A5_0001);
    wait_ready(10, 5);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (wb_cyc || ready || overrun) n++;
      step();
    end
    check("overrun_single_cycle", n, 0);

    // reset during BUS
    issue(32'h0000_0050, 32'h0, 4'b0000, 0, 32'h0, 0);
    step();
    arst = 1'b1;
    #1;
    check("async_rst_cyc_stb", {wb_cyc, wb_stb}, 0);
    step();
    step();
    arst = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (ready || wb_cyc) n++;
      step();
    end
    check("no_ready_after_rst", n, 0);

    // fresh read after reset
    issue(32'h0000_0080, 32'h0, 4'b0000, 1, 32'hCAFE_F00D, 0);
    slave_end(2, 1, 0, 32'hCAFE_F00D);
    wait_ready(10, 5);

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
